// File: rtl/fake_signal_check_pkg.sv
// Shared definitions for the fake-signal generator and checker.
// Holds the default pedestal and gain-ratio shift, the clock frequency,
// the HG/LG field positions inside the 24-bit ADC word and the pulse
// tracker state enumeration.
package fake_signal_check_pkg;

    localparam int unsigned PEDESTAL_DEFAULT = 200;          // ADC counts
    localparam int unsigned LG_SHIFT_DEFAULT = 5;            // HG/LG = 2**5
    localparam int unsigned CLOCK_FREQ_HZ    = 120_000_000;

    localparam int unsigned ADC_W    = 24;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned HG_MSB   = 23;
    localparam int unsigned HG_LSB   = 12;
    localparam int unsigned LG_MSB   = 11;
    localparam int unsigned LG_LSB   = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/fake_lg_expect.sv
// Expected low-gain value for a given high-gain value.
// Ports:
//   hg_i        - high-gain sample
//   hg_ge_ped_o - 1 when hg_i is at or above the pedestal
//   lg_exp_o    - ((hg_i - PEDESTAL) >> LG_SHIFT) + PEDESTAL, truncated;
//                 only meaningful when hg_ge_ped_o is 1
module fake_lg_expect
    import fake_signal_check_pkg::*;
#(
    parameter int unsigned PEDESTAL = PEDESTAL_DEFAULT,
    parameter int unsigned LG_SHIFT = LG_SHIFT_DEFAULT
) (
    input  logic [SAMPLE_W-1:0] hg_i,
    output logic                hg_ge_ped_o,
    output logic [SAMPLE_W-1:0] lg_exp_o
);

    localparam logic [SAMPLE_W:0] PED_EXT = (SAMPLE_W+1)'(PEDESTAL);

    logic [SAMPLE_W:0] excess;

    always_comb begin
        excess      = {1'b0, hg_i} - PED_EXT;
        hg_ge_ped_o = ({1'b0, hg_i} >= PED_EXT);
        lg_exp_o    = SAMPLE_W'((excess >> LG_SHIFT) + PED_EXT);
    end

endmodule

// File: rtl/fake_signal_check.sv
// Pulse statistics checker for the fake ADC signal.
// Registers the ADC word once, tracks pulses above PEDESTAL + THRESHOLD
// and reports width, peak, start-to-start interval and LG/HG consistency.
// Ports:
//   CLK, RESET     - clock and synchronous active-high reset
//   ENABLE         - checker active; when low the tracker idles and holds
//   CLEAR          - one-cycle pulse zeroing all statistics
//   ADC_IN         - HG in [23:12], LG in [11:0]
//   THRESHOLD      - pulse threshold in counts above PEDESTAL
//   PULSE_COUNT    - completed pulses (wrapping)
//   LAST_INTERVAL  - cycles between starts of the last two pulses
//   LAST_WIDTH     - above-threshold samples in the last pulse
//   LAST_PEAK      - maximum HG in the last pulse
//   LG_ERR_COUNT   - in-pulse samples whose LG disagrees with HG
//   PULSE_STROBE   - one cycle, LAST_* just updated
module fake_signal_check
    import fake_signal_check_pkg::*;
#(
    parameter int unsigned PEDESTAL = PEDESTAL_DEFAULT,
    parameter int unsigned LG_SHIFT = LG_SHIFT_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic                CLEAR,
    input  logic [ADC_W-1:0]    ADC_IN,
    input  logic [SAMPLE_W-1:0] THRESHOLD,
    output logic [31:0]         PULSE_COUNT,
    output logic [31:0]         LAST_INTERVAL,
    output logic [15:0]         LAST_WIDTH,
    output logic [SAMPLE_W-1:0] LAST_PEAK,
    output logic [15:0]         LG_ERR_COUNT,
    output logic                PULSE_STROBE
);

    localparam logic [SAMPLE_W:0] PED_EXT = (SAMPLE_W+1)'(PEDESTAL);

    logic [ADC_W-1:0]    adc_q;
    pulse_state_e        state_q;
    logic [15:0]         width_q;
    logic [SAMPLE_W-1:0] peak_q;
    logic [31:0]         interval_cnt_q;
    logic [31:0]         interval_cap_q;
    logic                first_q;
    logic [31:0]         pulse_count_q;
    logic [31:0]         last_interval_q;
    logic [15:0]         last_width_q;
    logic [SAMPLE_W-1:0] last_peak_q;
    logic [15:0]         lg_err_q;
    logic                strobe_q;

    logic [SAMPLE_W-1:0] hg;
    logic [SAMPLE_W-1:0] lg;
    logic [SAMPLE_W-1:0] lg_exp;
    logic                hg_ge_ped;
    logic                above;
    logic                lg_mismatch;
    logic [15:0]         width_d;
    logic [SAMPLE_W-1:0] peak_d;
    logic [31:0]         interval_cnt_d;
    logic [15:0]         lg_err_d;

    fake_lg_expect #(
        .PEDESTAL (PEDESTAL),
        .LG_SHIFT (LG_SHIFT)
    ) u_lg_expect (
        .hg_i        (hg),
        .hg_ge_ped_o (hg_ge_ped),
        .lg_exp_o    (lg_exp)
    );

    always_comb begin
        hg    = adc_q[HG_MSB:HG_LSB];
        lg    = adc_q[LG_MSB:LG_LSB];
        // 13-bit compare so PEDESTAL + THRESHOLD cannot wrap.
        above = ({1'b0, hg} >= (PED_EXT + {1'b0, THRESHOLD}));
        // Samples belonging to a pulse: the entry sample, every sample while
        // HIGH (including the one that ends it); sub-pedestal HG is skipped.
        lg_mismatch    = ((state_q == ST_HIGH) || above) && hg_ge_ped && (lg != lg_exp);
        width_d        = (width_q == '1)        ? width_q        : width_q + 16'd1;
        peak_d         = (hg > peak_q)          ? hg             : peak_q;
        interval_cnt_d = (interval_cnt_q == '1) ? interval_cnt_q : interval_cnt_q + 32'd1;
        lg_err_d       = (lg_err_q == '1)       ? lg_err_q       : lg_err_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            adc_q           <= '0;
            state_q         <= ST_IDLE;
            width_q         <= '0;
            peak_q          <= '0;
            interval_cnt_q  <= '0;
            interval_cap_q  <= '0;
            first_q         <= 1'b1;
            pulse_count_q   <= '0;
            last_interval_q <= '0;
            last_width_q    <= '0;
            last_peak_q     <= '0;
            lg_err_q        <= '0;
            strobe_q        <= 1'b0;
        end else begin
            adc_q    <= ADC_IN;
            strobe_q <= 1'b0;
            if (CLEAR) begin
                state_q         <= ST_IDLE;
                width_q         <= '0;
                peak_q          <= '0;
                interval_cnt_q  <= '0;
                interval_cap_q  <= '0;
                first_q         <= 1'b1;
                pulse_count_q   <= '0;
                last_interval_q <= '0;
                last_width_q    <= '0;
                last_peak_q     <= '0;
                lg_err_q        <= '0;
            end else if (!ENABLE) begin
                // Abort any pulse in progress; statistics and interval hold.
                state_q <= ST_IDLE;
            end else begin
                interval_cnt_q <= interval_cnt_d;
                if (lg_mismatch) begin
                    lg_err_q <= lg_err_d;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (above) begin
                            state_q        <= ST_HIGH;
                            width_q        <= 16'd1;
                            peak_q         <= hg;
                            interval_cap_q <= first_q ? '0 : interval_cnt_q;
                            first_q        <= 1'b0;
                            interval_cnt_q <= 32'd1;
                        end
                    end
                    ST_HIGH: begin
                        if (above) begin
                            width_q <= width_d;
                            peak_q  <= peak_d;
                        end else begin
                            state_q         <= ST_IDLE;
                            last_width_q    <= width_q;
                            last_peak_q     <= peak_q;
                            last_interval_q <= interval_cap_q;
                            pulse_count_q   <= pulse_count_q + 32'd1;
                            strobe_q        <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign PULSE_COUNT   = pulse_count_q;
    assign LAST_INTERVAL = last_interval_q;
    assign LAST_WIDTH    = last_width_q;
    assign LAST_PEAK     = last_peak_q;
    assign LG_ERR_COUNT  = lg_err_q;
    assign PULSE_STROBE  = strobe_q;

endmodule

// File: tb/tb_fake_signal_check.sv
module tb_fake_signal_check;

    logic        CLK = 1'b0;
    logic        RESET, ENABLE, CLEAR;
    logic [23:0] ADC_IN;
    logic [11:0] THRESHOLD;
    logic [31:0] PULSE_COUNT, LAST_INTERVAL;
    logic [15:0] LAST_WIDTH, LG_ERR_COUNT;
    logic [11:0] LAST_PEAK;
    logic        PULSE_STROBE;

    fake_signal_check #(.PEDESTAL(200), .LG_SHIFT(5)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ENABLE        (ENABLE),
        .CLEAR         (CLEAR),
        .ADC_IN        (ADC_IN),
        .THRESHOLD     (THRESHOLD),
        .PULSE_COUNT   (PULSE_COUNT),
        .LAST_INTERVAL (LAST_INTERVAL),
        .LAST_WIDTH    (LAST_WIDTH),
        .LAST_PEAK     (LAST_PEAK),
        .LG_ERR_COUNT  (LG_ERR_COUNT),
        .PULSE_STROBE  (PULSE_STROBE)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int unsigned strobe_seen = 0;
    always @(negedge CLK) if (PULSE_STROBE === 1'b1) strobe_seen <= strobe_seen + 1;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned last_start = 0;

    typedef struct {
        int unsigned thr, hg0, lg0, hg, lg, n, bad, idle_hg, idle_lg, spacing;
        bit          fires;
        int unsigned exp_w, exp_p, exp_c, exp_i, exp_e;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input int unsigned w, p, c, i, e);
        chk({tag, "_width"},    32'(LAST_WIDTH),   w);
        chk({tag, "_peak"},     32'(LAST_PEAK),    p);
        chk({tag, "_count"},    PULSE_COUNT,       c);
        chk({tag, "_interval"}, LAST_INTERVAL,     i);
        chk({tag, "_lgerr"},    32'(LG_ERR_COUNT), e);
    endtask

    // Drives the first idle sample after a pulse and checks strobe timing.
    task automatic end_check(input string tag, input bit fires, input int unsigned idle_hg, idle_lg,
                             input int unsigned w, p, c, i, e);
        @(negedge CLK);
        ADC_IN = {12'(idle_hg), 12'(idle_lg)};
        @(posedge CLK); #1;
        chk({tag, "_strobe_early"}, 32'(PULSE_STROBE), 0);
        @(posedge CLK); #1;
        chk({tag, "_strobe"}, 32'(PULSE_STROBE), 32'(fires));
        @(posedge CLK); #1;
        chk({tag, "_strobe_late"}, 32'(PULSE_STROBE), 0);
        chk_outputs(tag, w, p, c, i, e);
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int unsigned target;
        int unsigned hg, lg;
        THRESHOLD = 12'(v.thr);
        target = (v.spacing == 0) ? cyc + 5 : last_start + v.spacing;
        @(negedge CLK);
        if (cyc > target) chk({tag, "_spacing_reachable"}, cyc, target);
        while (cyc < target) begin
            ADC_IN = {12'(v.idle_hg), 12'(v.idle_lg)};
            @(negedge CLK);
        end
        if (v.fires) last_start = cyc;
        for (int unsigned k = 0; k < v.n; k++) begin
            if (k > 0) @(negedge CLK);
            hg = (k == 0) ? v.hg0 : v.hg;
            lg = (k == 0) ? v.lg0 : v.lg;
            if (((v.bad >> k) & 1) != 0) lg = lg + 1;
            ADC_IN = {12'(hg), 12'(lg)};
        end
        end_check(tag, v.fires, v.idle_hg, v.idle_lg, v.exp_w, v.exp_p, v.exp_c, v.exp_i, v.exp_e);
    endtask

    function automatic logic [11:0] lg_of(input int unsigned hg);
        return 12'(((hg - 200) >> 5) + 200);
    endfunction

    vec_t muon;
    int unsigned s0;

    initial begin
        //           thr  hg0   lg0  hg    lg   n  bad      idle     spc  fire  w  peak  cnt  intv  lgerr
        vecs[0] = '{ 50, 2047, 257, 2047, 257, 4, 0,     200, 200,   0,  1'b1, 4, 2047, 1,    0,   0};
        vecs[1] = '{ 50, 2047, 257, 2047, 257, 4, 0,     200, 200, 1000, 1'b1, 4, 2047, 2, 1000,   0};
        vecs[2] = '{ 50, 2047, 257, 2047, 257, 4, 4'b0110, 200, 200, 50, 1'b1, 4, 2047, 3,   50,   2};
        vecs[3] = '{100, 1000, 225, 1000, 225, 7, 0,     200, 200,  20,  1'b1, 7, 1000, 4,   20,   2};
        vecs[4] = '{ 50,  250, 201,  250, 201, 3, 0,     200, 200,  30,  1'b1, 3,  250, 5,   30,   2};
        vecs[5] = '{ 50,  249,   0,  249,   0, 3, 0,     200, 200,  20,  1'b0, 3,  250, 5,   30,   2};
        vecs[6] = '{ 50, 4095, 321, 4095, 321, 2, 0,     150,   0,  60,  1'b1, 2, 4095, 6,   60,   2};
        vecs[7] = '{ 50, 3000, 287,  500, 209, 3, 0,     200, 200,  30,  1'b1, 3, 3000, 7,   30,   2};
        muon    = '{ 50, 2047, 257, 2047, 257, 4, 0,     200, 200,   0,  1'b1, 4, 2047, 1,    0,   0};

        RESET = 1'b1; ENABLE = 1'b1; CLEAR = 1'b1; ADC_IN = {12'd200, 12'd200}; THRESHOLD = 12'd50;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_strobe", 32'(PULSE_STROBE), 0);
        chk_outputs("reset", 0, 0, 0, 0, 0);
        @(negedge CLK);
        RESET = 1'b0; CLEAR = 1'b0;

        foreach (vecs[k]) apply_vec($sformatf("vec%0d", k), vecs[k]);

        // Shower ramp after a clear: first pulse again, so interval reads 0.
        @(negedge CLK); CLEAR = 1'b1;
        @(negedge CLK); CLEAR = 1'b0;
        chk_outputs("clear", 0, 0, 0, 0, 0);
        THRESHOLD = 12'd50;
        for (int unsigned h = 200; h <= 2046; h++) begin
            @(negedge CLK);
            ADC_IN = {12'(h), lg_of(h)};
        end
        end_check("ramp", 1'b1, 200, 200, 1797, 2046, 1, 0, 0);

        // ENABLE low while the 2nd pulse sample is evaluated: pulse aborted.
        s0 = strobe_seen;
        @(negedge CLK); ADC_IN = {12'd2047, 12'd257};
        @(negedge CLK);
        @(negedge CLK); ENABLE = 1'b0;
        @(negedge CLK);
        @(negedge CLK); ADC_IN = {12'd200, 12'd200};
        @(negedge CLK);
        @(negedge CLK); ENABLE = 1'b1;
        repeat (4) @(negedge CLK);
        chk("abort_strobes", strobe_seen - s0, 0);
        chk_outputs("abort", 1797, 2046, 1, 0, 0);

        // CLEAR on the cycle that would produce the strobe.
        s0 = strobe_seen;
        repeat (4) begin @(negedge CLK); ADC_IN = {12'd2047, 12'd257}; end
        @(negedge CLK); ADC_IN = {12'd200, 12'd200};
        @(posedge CLK);
        @(negedge CLK); CLEAR = 1'b1;
        @(posedge CLK); #1;
        chk("clear_end_strobe", 32'(PULSE_STROBE), 0);
        chk_outputs("clear_end", 0, 0, 0, 0, 0);
        @(negedge CLK); CLEAR = 1'b0;
        repeat (3) @(negedge CLK);
        chk("clear_end_strobes", strobe_seen - s0, 0);

        // One good pulse, then RESET for one cycle in the middle of the next.
        apply_vec("pre_reset", muon);
        s0 = strobe_seen;
        repeat (4) begin @(negedge CLK); ADC_IN = {12'd2047, 12'd257}; end
        RESET = 1'b1;
        @(negedge CLK); ADC_IN = {12'd200, 12'd200}; RESET = 1'b0;
        repeat (4) @(negedge CLK);
        chk("midreset_strobes", strobe_seen - s0, 0);
        chk_outputs("midreset", 0, 0, 0, 0, 0);
        apply_vec("post_reset", muon);

        // THRESHOLD raised mid-pulse: the 3rd sample already ends the pulse.
        @(negedge CLK); ADC_IN = {12'd1000, 12'd225};
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK); THRESHOLD = 12'd1000;
        @(posedge CLK); #1;
        chk("thr_change_strobe", 32'(PULSE_STROBE), 1);
        chk("thr_change_width", 32'(LAST_WIDTH), 2);
        chk("thr_change_peak", 32'(LAST_PEAK), 1000);
        chk("thr_change_count", PULSE_COUNT, 2);
        @(negedge CLK); ADC_IN = {12'd200, 12'd200}; THRESHOLD = 12'd50;
        repeat (3) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
